// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the pipelined MIPS CPU. Holds the program counter,
// presents it to the instruction memory, captures the returned word into the
// IF/ID pipeline register and selects the next PC from decode-stage control.
// Architectural branch delay slots are honoured: the word fetched while a
// branch/jump sits in ID always enters IF/ID, so nothing is ever flushed.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   IM_WORDS  instruction memory depth in words (address check only)
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   stall        hazard-unit freeze of PC and IF/ID
//   npc_sel      00 PC+4, 01 branch, 10 j/jal, 11 jr/jalr
//   cmp_true     branch condition from the ID comparator
//   jr_target    forwarded rs value for jr/jalr
//   if_instr     instruction word for if_pc (combinational memory)
//   if_pc        current fetch address
//   id_pc        PC of the instruction held in IF/ID
//   id_instr     instruction held in IF/ID
//   id_pc8       id_pc + 8, link value for jal/jalr
//   id_exc_code  fetch exception code of the IF/ID instruction (0 = none)
//
// Build option
//   FETCH_ADDR_CHECK_EN  when defined, misaligned or out-of-range fetches are
//                        captured as a nop tagged with AdEL (code 4). When
//                        undefined, id_exc_code is always 0.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        cmp_true,
  input  logic [31:0] jr_target,
  input  logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc8,
  output logic [4:0]  id_exc_code
);

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JREG   = 2'b11
  } npc_sel_e;

  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  npc_sel_e    sel;

  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [4:0]  id_exc_q,   id_exc_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        fetch_fault;

  assign sel = npc_sel_e'(npc_sel);

  // ---------------------------------------------------------------------------
  // Fetch address check
  // ---------------------------------------------------------------------------
`ifdef FETCH_ADDR_CHECK_EN
  // 33-bit bounds so that a memory ending at the top of the address space
  // does not wrap the upper limit to a small value.
  localparam logic [32:0] IM_LO = {1'b0, RESET_PC};
  localparam logic [32:0] IM_HI = IM_LO + (33'(IM_WORDS) << 2);

  always_comb begin
    fetch_fault = 1'b0;
    if (pc_q[1:0] != 2'b00)        fetch_fault = 1'b1;
    if ({1'b0, pc_q} <  IM_LO)     fetch_fault = 1'b1;
    if ({1'b0, pc_q} >= IM_HI)     fetch_fault = 1'b1;
  end
`else
  // Depth only matters to the address check.
  localparam int unsigned unused_im_words = IM_WORDS;

  assign fetch_fault = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-PC candidates, all relative to the instruction currently in ID
  // ---------------------------------------------------------------------------
  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{id_instr_q[15]}}, id_instr_q[15:0], 2'b00};
  assign br_target = id_pc_q + 32'd4 + br_offset;
  assign j_target  = {id_pc_q[31:28], id_instr_q[25:0], 2'b00};

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_exc_d   = id_exc_q;

    // A stall freezes everything, so a redirect in ID is simply
    // re-evaluated on the first unstalled cycle.
    if (!stall) begin
      unique case (sel)
        NPC_SEQ:    pc_d = pc_plus4;
        NPC_BRANCH: pc_d = cmp_true ? br_target : pc_plus4;
        NPC_JUMP:   pc_d = j_target;
        NPC_JREG:   pc_d = jr_target;
        default:    pc_d = pc_plus4;
      endcase

      // The current fetch always enters IF/ID: it is either the next
      // sequential instruction or the delay slot of the redirect in ID.
      id_pc_d = pc_q;
      if (fetch_fault) begin
        id_instr_d = NOP;
        id_exc_d   = EXC_ADEL;
      end else begin
        id_instr_d = if_instr;
        id_exc_d   = EXC_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= NOP;
      id_exc_q   <= EXC_NONE;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_exc_q   <= id_exc_d;
    end
  end

  assign if_pc       = pc_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_exc_code = id_exc_q;
  assign id_pc8      = id_pc_q + 32'd8;

endmodule
